// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the alu_mdu execution unit:
//   - 4-bit opcode constants for the single-cycle ALU and the iterative MDU,
//   - the handshake FSM state type (IDLE/BUSY/DONE),
//   - is_mdu_op(), which tells the top whether an opcode needs the iterative unit.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SGE   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_MULHU = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;
   localparam logic [3:0] OP_REMU  = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for the four opcodes that are executed by the multi-cycle unit.
   function automatic logic is_mdu_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv
// Iterative unsigned multiply / divide, one bit per clock.
//   MUL/MULHU : shift-add, multiplier in the low half of the shared register,
//               partial product accumulates in the high half.
//   DIVU/REMU : restoring division, dividend shifted in from the low half,
//               remainder builds in the high half, quotient bits enter at bit 0.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load operands/opcode and begin (ignored fields otherwise)
//   op         opcode (only MUL/MULHU/DIVU/REMU are meaningful)
//   a, b       operands
//   done       high during the last iteration cycle; result is valid with it
//   result     selected half of the value the register takes on that edge
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic [2*W-1:0] acc_q, acc_d, acc_step;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [3:0]     op_q, op_d;
   logic [CW-1:0]  count_q, count_d;
   logic           active_q, active_d;
   logic           div_op;
   logic [W:0]     add_sum;
   logic [W:0]     rem_try;

   assign div_op = (op_q == OP_DIVU) || (op_q == OP_REMU);
   assign done   = active_q && (count_q == CW'(W - 1));

   // One iteration of either algorithm. For division the trial subtraction is
   // W+1 bits wide: the shifted remainder can exceed W bits, and bit W of the
   // difference doubles as the "went negative, restore" indicator. Division by
   // zero needs no special case: every trial succeeds, giving an all-ones
   // quotient and leaving the dividend as the remainder.
   always_comb begin
      add_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      rem_try = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
      if (div_op) begin
         if (!rem_try[W]) begin
            acc_step = {rem_try[W-1:0], acc_q[W-2:0], 1'b1};
         end else begin
            acc_step = {acc_q[2*W-2:0], 1'b0};
         end
      end else begin
         acc_step = {add_sum, acc_q[W-1:1]};
      end
   end

   // High half holds MULHU product bits and the REMU remainder; low half holds
   // the MUL product bits and the DIVU quotient.
   assign result = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? acc_step[2*W-1:W]
                                                             : acc_step[W-1:0];

   // Load on start, otherwise iterate while active and stop after W steps.
   always_comb begin
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      count_d  = count_q;
      active_d = active_q;
      if (start) begin
         op_d     = op;
         count_d  = '0;
         active_d = 1'b1;
         if ((op == OP_DIVU) || (op == OP_REMU)) begin
            opnd_d = b;
            acc_d  = {{W{1'b0}}, a};
         end else begin
            opnd_d = a;
            acc_d  = {{W{1'b0}}, b};
         end
      end else if (active_q) begin
         acc_d   = acc_step;
         count_d = count_q + CW'(1);
         if (done) begin
            active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         count_q  <= count_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu
// Handshaked execution unit: single-cycle ALU ops plus an optional iterative
// unsigned multiply/divide, with a registered result stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake; ctrl, a, b, in_tag captured on accept
//   out_valid / out_ready    result handshake; outputs held while stalled
//   c                        result
//   zero, over, c_out        flags (over/c_out only meaningful for ADD/SUB)
//   illegal                  opcode not supported (c and flags forced to 0)
//   out_tag                  tag of the request that produced the result
module alu_mdu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_BITS  = 4,
   parameter int TAG_WIDTH  = 4,
   parameter int ENABLE_MDU = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_BITS-1:0]  ctrl,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] c,
   output logic                  zero,
   output logic                  over,
   output logic                  c_out,
   output logic                  illegal,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int W = DATA_WIDTH;

   state_t               state_q, state_d;
   logic [W-1:0]         c_q, c_d;
   logic                 zero_q, zero_d;
   logic                 over_q, over_d;
   logic                 c_out_q, c_out_d;
   logic                 illegal_q, illegal_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;

   logic [3:0]   ctrl_lo;
   logic         ctrl_hi_zero;
   logic         mdu_ok;
   logic         accept;
   logic         mdu_start;
   logic         mdu_done;
   logic [W-1:0] mdu_result;

   logic [W:0]   add_sum;
   logic [W:0]   sub_sum;
   logic [W-1:0] alu_c;
   logic         alu_over;
   logic         alu_c_out;
   logic         alu_illegal;
   logic         alu_zero;

   // Opcodes are 4 bits; any set bit above them makes the request illegal.
   assign ctrl_lo      = ctrl[3:0];
   assign ctrl_hi_zero = ((ctrl >> 4) == '0);
   assign mdu_ok       = (ENABLE_MDU != 0) && ctrl_hi_zero && is_mdu_op(ctrl_lo);

   // A new request can enter when idle, or when the held result leaves on the
   // same edge, which gives back-to-back single-cycle throughput.
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);

   // Single-cycle ALU. MDU opcodes land in the default branch, so with the MDU
   // disabled they come out illegal with no extra decoding.
   always_comb begin
      alu_c       = '0;
      alu_over    = 1'b0;
      alu_c_out   = 1'b0;
      alu_illegal = 1'b0;
      add_sum     = {1'b0, a} + {1'b0, b};
      sub_sum     = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
      if (!ctrl_hi_zero) begin
         alu_illegal = 1'b1;
      end else begin
         case (ctrl_lo)
            OP_AND: alu_c = a & b;
            OP_OR:  alu_c = a | b;
            OP_NOR: alu_c = ~(a | b);
            OP_ADD: begin
               alu_c     = add_sum[W-1:0];
               alu_c_out = add_sum[W];
               alu_over  = (a[W-1] == b[W-1]) && (add_sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
               alu_c     = sub_sum[W-1:0];
               alu_c_out = sub_sum[W];
               alu_over  = (a[W-1] != b[W-1]) && (sub_sum[W-1] != a[W-1]);
            end
            OP_SLT: alu_c = {{(W-1){1'b0}}, (a < b)};
            OP_SGE: alu_c = {{(W-1){1'b0}}, (a >= b)};
            default: alu_illegal = 1'b1;
         endcase
      end
      alu_zero = !alu_illegal && (alu_c == '0);
   end

   alu_iter_muldiv #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (mdu_start),
      .op     (ctrl_lo),
      .a      (a),
      .b      (b),
      .done   (mdu_done),
      .result (mdu_result)
   );

   // Next-state and output-register logic. The result registers only change
   // on an accept (single-cycle op) or when the iterative unit finishes, so
   // they stay put while the consumer stalls in DONE.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      zero_d    = zero_q;
      over_d    = over_q;
      c_out_d   = c_out_q;
      illegal_d = illegal_q;
      tag_d     = tag_q;
      mdu_start = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               tag_d = in_tag;
               if (mdu_ok) begin
                  state_d   = BUSY;
                  mdu_start = 1'b1;
               end else begin
                  state_d   = DONE;
                  c_d       = alu_c;
                  zero_d    = alu_zero;
                  over_d    = alu_over;
                  c_out_d   = alu_c_out;
                  illegal_d = alu_illegal;
               end
            end else if ((state_q == DONE) && out_ready) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (mdu_done) begin
               state_d   = DONE;
               c_d       = mdu_result;
               zero_d    = (mdu_result == '0);
               over_d    = 1'b0;
               c_out_d   = 1'b0;
               illegal_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         c_q       <= '0;
         zero_q    <= 1'b0;
         over_q    <= 1'b0;
         c_out_q   <= 1'b0;
         illegal_q <= 1'b0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         zero_q    <= zero_d;
         over_q    <= over_d;
         c_out_q   <= c_out_d;
         illegal_q <= illegal_d;
         tag_q     <= tag_d;
      end
   end

   assign c       = c_q;
   assign zero    = zero_q;
   assign over    = over_q;
   assign c_out   = c_out_q;
   assign illegal = illegal_q;
   assign out_tag = tag_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu
// Self-checking bench for alu_mdu (32-bit, MDU enabled): a table of directed
// vectors, hand-written multi-cycle sequences (busy stall, back-to-back stream,
// consumer stall, reset mid-divide) and a randomized run against a plain
// arithmetic reference model.
module tb_alu_mdu;

   localparam logic [3:0] T_AND   = 4'b0000;
   localparam logic [3:0] T_OR    = 4'b0001;
   localparam logic [3:0] T_ADD   = 4'b0010;
   localparam logic [3:0] T_SGE   = 4'b0101;
   localparam logic [3:0] T_SUB   = 4'b0110;
   localparam logic [3:0] T_SLT   = 4'b0111;
   localparam logic [3:0] T_MUL   = 4'b1000;
   localparam logic [3:0] T_MULHU = 4'b1001;
   localparam logic [3:0] T_DIVU  = 4'b1010;
   localparam logic [3:0] T_REMU  = 4'b1011;
   localparam logic [3:0] T_NOR   = 4'b1100;
   localparam longint     S_MAX   = 64'sd2147483647;
   localparam longint     S_MIN   = -64'sd2147483648;

   typedef struct packed {
      logic [31:0] c;
      logic        zero;
      logic        over;
      logic        c_out;
      logic        illegal;
   } result_t;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      result_t     exp;
      int          lat;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] c;
   logic        zero;
   logic        over;
   logic        c_out;
   logic        illegal;
   logic [3:0]  out_tag;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mdu #(
      .DATA_WIDTH (32),
      .CTRL_BITS  (4),
      .TAG_WIDTH  (4),
      .ENABLE_MDU (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ctrl      (ctrl),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .zero      (zero),
      .over      (over),
      .c_out     (c_out),
      .illegal   (illegal),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a wedged DUT still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected end of test first");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model straight from the opcode definitions, using wide
   // arithmetic and signed range checks rather than carry-bit tricks.
   function automatic result_t ref_model(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
      result_t     r;
      logic [63:0] wide;
      longint      sx;
      longint      sy;
      longint      sres;
      r  = '0;
      sx = $signed(x);
      sy = $signed(y);
      case (op)
         T_AND: r.c = x & y;
         T_OR:  r.c = x | y;
         T_NOR: r.c = ~(x | y);
         T_ADD: begin
            wide    = {32'd0, x} + {32'd0, y};
            r.c     = wide[31:0];
            r.c_out = wide[32];
            sres    = sx + sy;
            r.over  = (sres > S_MAX) || (sres < S_MIN);
         end
         T_SUB: begin
            r.c     = x - y;
            r.c_out = (x >= y);
            sres    = sx - sy;
            r.over  = (sres > S_MAX) || (sres < S_MIN);
         end
         T_SLT: r.c = (x < y) ? 32'd1 : 32'd0;
         T_SGE: r.c = (x >= y) ? 32'd1 : 32'd0;
         T_MUL: begin
            wide = {32'd0, x} * {32'd0, y};
            r.c  = wide[31:0];
         end
         T_MULHU: begin
            wide = {32'd0, x} * {32'd0, y};
            r.c  = wide[63:32];
         end
         T_DIVU: r.c = (y == 0) ? 32'hFFFF_FFFF : x / y;
         T_REMU: r.c = (y == 0) ? x : x % y;
         default: r.illegal = 1'b1;
      endcase
      r.zero = !r.illegal && (r.c == 32'd0);
      return r;
   endfunction

   function automatic bit is_multi(input logic [3:0] op);
      return (op == T_MUL) || (op == T_MULHU) || (op == T_DIVU) || (op == T_REMU);
   endfunction

   function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] ec, input logic ez,
                               input logic eo, input logic eco, input logic eill, input int lat);
      vec_t v;
      v.name          = name;
      v.op            = op;
      v.x             = x;
      v.y             = y;
      v.exp.c         = ec;
      v.exp.zero      = ez;
      v.exp.over      = eo;
      v.exp.c_out     = eco;
      v.exp.illegal   = eill;
      v.lat           = lat;
      return v;
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [5];
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
      return $urandom;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input result_t exp, input logic [3:0] exp_tag);
      n_checks++;
      if (out_valid !== 1'b1 || c !== exp.c || zero !== exp.zero || over !== exp.over ||
          c_out !== exp.c_out || illegal !== exp.illegal || out_tag !== exp_tag) begin
         n_fail++;
         $display("[TB] FAIL %s: got valid=%b c=%h z=%b o=%b co=%b ill=%b tag=%h, expected valid=1 c=%h z=%b o=%b co=%b ill=%b tag=%h",
                  name, out_valid, c, zero, over, c_out, illegal, out_tag,
                  exp.c, exp.zero, exp.over, exp.c_out, exp.illegal, exp_tag);
      end
   endtask

   // Offer a request and hold it until accepted; returns just after the
   // accepting edge with the inputs scrambled so late changes are visible.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [3:0] t, output bit ok);
      int guard;
      guard    = 0;
      ctrl     = op;
      a        = x;
      b        = y;
      in_tag   = t;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 100) begin
         step();
         guard++;
      end
      checkVal("accept_ready", {31'd0, in_ready}, 32'd1);
      ok = (in_ready === 1'b1);
      if (ok) step();
      in_valid = 1'b0;
      ctrl     = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
      in_tag   = 4'($urandom);
   endtask

   task automatic waitResult(input int start, output int lat, output bit ready_seen);
      lat        = start;
      ready_seen = 1'b0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready === 1'b1) ready_seen = 1'b1;
         step();
         lat++;
      end
   endtask

   vec_t        vecs [14];
   vec_t        stream [4];
   result_t     exp_r;
   bit          ok;
   bit          ready_seen;
   bit          bad;
   int          lat;
   int          k;
   logic [3:0]  legal_ops [11];
   logic [3:0]  op;
   logic [31:0] x;
   logic [31:0] y;

   initial begin
      vecs[0]  = mk("add_ovf",    T_ADD,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1, 0, 0);
      vecs[1]  = mk("sub_ovf",    T_SUB,   32'h8000_0001, 32'h0000_0010, 32'h7FFF_FFF1, 0, 1, 1, 0, 0);
      vecs[2]  = mk("sub_zero",   T_SUB,   32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 0);
      vecs[3]  = mk("sub_borrow", T_SUB,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
      vecs[4]  = mk("add_wrap",   T_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 0);
      vecs[5]  = mk("slt_true",   T_SLT,   32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 0, 0, 0, 0, 0);
      vecs[6]  = mk("slt_false",  T_SLT,   32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1, 0, 0, 0, 0);
      vecs[7]  = mk("and_mask",   T_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 0, 0);
      vecs[8]  = mk("illegal",    4'b0011, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 0, 0, 0, 1, 0);
      vecs[9]  = mk("mul_lo",     T_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 32);
      vecs[10] = mk("divu",       T_DIVU,  32'd100,       32'd7,         32'd14,        0, 0, 0, 0, 32);
      vecs[11] = mk("remu",       T_REMU,  32'd100,       32'd7,         32'd2,         0, 0, 0, 0, 32);
      vecs[12] = mk("divu_zero",  T_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 0, 0, 0, 0, 32);
      vecs[13] = mk("remu_zero",  T_REMU,  32'd5,         32'd0,         32'd5,         0, 0, 0, 0, 32);

      stream[0] = mk("stream_and", T_AND, 32'h1234_5678, 32'h0F0F_0F0F, '0, 0, 0, 0, 0, 0);
      stream[1] = mk("stream_or",  T_OR,  32'h1200_0000, 32'h0000_0034, '0, 0, 0, 0, 0, 0);
      stream[2] = mk("stream_nor", T_NOR, 32'hFFFF_0000, 32'h0000_FFFF, '0, 0, 0, 0, 0, 0);
      stream[3] = mk("stream_sge", T_SGE, 32'hFFFF_BEEF, 32'h0000_0003, '0, 0, 0, 0, 0, 0);

      legal_ops = '{T_AND, T_OR, T_ADD, T_SGE, T_SUB, T_SLT, T_MUL, T_MULHU, T_DIVU, T_REMU, T_NOR};

      rst       = 1'b1;
      in_valid  = 1'b0;
      ctrl      = '0;
      a         = '0;
      b         = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;

      $display("[TB] reset state");
      checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkVal("reset_in_ready",  {31'd0, in_ready}, 32'd1);
      checkVal("reset_c",         c, 32'd0);
      checkVal("reset_flags",     {28'd0, zero, over, c_out, illegal}, 32'd0);
      checkVal("reset_tag",       {28'd0, out_tag}, 32'd0);

      $display("[TB] directed vector table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, 4'(i), ok);
         if (ok) begin
            waitResult(0, lat, ready_seen);
            checkVal({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            checkVal({vecs[i].name, "_busy_ready"}, {31'd0, ready_seen}, 32'd0);
            checkOutput(vecs[i].name, vecs[i].exp, 4'(i));
            step();
            checkVal({vecs[i].name, "_handoff"}, {31'd0, out_valid}, 32'd0);
         end
      end

      $display("[TB] MULHU with a request offered while busy");
      applyStimulus(T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, ok);
      bad      = 1'b0;
      k        = 0;
      ctrl     = T_ADD;
      a        = 32'd1;
      b        = 32'd1;
      in_tag   = 4'd9;
      in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         step();
         k++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      end
      in_valid = 1'b0;
      waitResult(k, lat, ready_seen);
      checkVal("mulhu_busy_ignores_req", {30'd0, bad, ready_seen}, 32'd0);
      checkVal("mulhu_latency", lat, 32);
      exp_r = '0;
      exp_r.c = 32'hFFFF_FFFE;
      checkOutput("mulhu", exp_r, 4'd5);
      step();
      checkVal("mulhu_no_extra_result", {31'd0, out_valid}, 32'd0);

      $display("[TB] back-to-back stream and consumer stall");
      ctrl     = stream[0].op;
      a        = stream[0].x;
      b        = stream[0].y;
      in_tag   = 4'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         exp_r = ref_model(stream[i].op, stream[i].x, stream[i].y);
         checkOutput(stream[i].name, exp_r, 4'(i + 1));
         if (i < 3) begin
            ctrl   = stream[i+1].op;
            a      = stream[i+1].x;
            b      = stream[i+1].y;
            in_tag = 4'(i + 2);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
         end
      end
      exp_r = '0;
      exp_r.c = 32'd1;
      for (int j = 0; j < 3; j++) begin
         step();
         checkOutput("stall_hold", exp_r, 4'd4);
         checkVal("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      checkVal("stall_release", {31'd0, out_valid}, 32'd0);

      $display("[TB] reset during DIVU");
      applyStimulus(T_DIVU, 32'd1000, 32'd3, 4'd7, ok);
      for (int j = 0; j < 10; j++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkVal("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      checkVal("rst_mid_in_ready",  {31'd0, in_ready}, 32'd1);
      checkVal("rst_mid_outputs",   {c[27:0], zero, over, c_out, illegal}, 32'd0);
      checkVal("rst_mid_c",         c, 32'd0);
      checkVal("rst_mid_tag",       {28'd0, out_tag}, 32'd0);
      bad = 1'b0;
      for (int j = 0; j < 40; j++) begin
         step();
         if (out_valid !== 1'b0) bad = 1'b1;
      end
      checkVal("rst_mid_no_result", {31'd0, bad}, 32'd0);
      applyStimulus(4'b0011, 32'hDEAD_BEEF, 32'h1, 4'd3, ok);
      if (ok) begin
         waitResult(0, lat, ready_seen);
         checkVal("post_rst_illegal_latency", lat, 0);
         exp_r = '0;
         exp_r.illegal = 1'b1;
         checkOutput("post_rst_illegal", exp_r, 4'd3);
         step();
      end

      $display("[TB] randomized run against reference model");
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(4) == 0) op = 4'($urandom);
         else op = legal_ops[$urandom_range(10)];
         x = pick_operand();
         y = pick_operand();
         applyStimulus(op, x, y, 4'(i), ok);
         if (ok) begin
            exp_r = ref_model(op, x, y);
            waitResult(0, lat, ready_seen);
            checkVal("rand_latency", lat, is_multi(op) ? 32 : 0);
            checkOutput("rand_result", exp_r, 4'(i));
            out_ready = 1'b0;
            for (int j = 0; j < int'($urandom_range(2)); j++) begin
               step();
               checkOutput("rand_stall_hold", exp_r, 4'(i));
            end
            out_ready = 1'b1;
            step();
            checkVal("rand_handoff", {31'd0, out_valid}, 32'd0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
